// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a two-entry skid buffer and branch resolution at accept.
// Define EXMEM_PERF_CNT_EN to compile in the stall/taken performance counters.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_alu_result,
  output logic [31:0] m_store_data,
  output logic [4:0]  m_rd_addr,
  output logic        m_reg_write,
  output logic        m_mem_read,
  output logic        m_mem_write,
  input  logic        flush,
  output logic        br_redirect,
  output logic [31:0] br_target,
  output logic [31:0] stall_cnt,
  output logic [31:0] taken_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  function automatic logic branch_taken(input logic       br,
                                        input logic [2:0] f3,
                                        input logic       zf,
                                        input logic       lsb);
    logic t;
    case (f3)
      3'b000:         t = zf;
      3'b001:         t = !zf;
      3'b100, 3'b110: t = lsb;
      3'b101, 3'b111: t = !lsb;
      default:        t = 1'b0;
    endcase
    return br && t;
  endfunction

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;
  logic   accept;
  logic   drain;

  // Skid register only fills when main stalls, so readiness depends purely on stored state.
  assign ex_ready = (state_q != TWO);
  assign m_valid  = (state_q != EMPTY);
  assign accept   = ex_valid && ex_ready;
  assign drain    = m_valid && m_ready;

  always_comb begin
    new_entry            = '0;
    new_entry.alu_result = alu_result;
    new_entry.store_data = store_data;
    new_entry.rd_addr    = rd_addr;
    new_entry.reg_write  = reg_write;
    new_entry.mem_read   = mem_read;
    new_entry.mem_write  = mem_write;
    new_entry.taken      = branch_taken(branch, funct3, zero_flag, alu_result[0]);
    new_entry.target     = pc + imm;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = new_entry;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = new_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = new_entry;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign m_alu_result = main_q.alu_result;
  assign m_store_data = main_q.store_data;
  assign m_rd_addr    = main_q.rd_addr;
  assign m_reg_write  = main_q.reg_write;
  assign m_mem_read   = main_q.mem_read;
  assign m_mem_write  = main_q.mem_write;

  // Redirect fires only as the taken branch actually leaves; a flush cancels the hand-off.
  assign br_redirect = drain && main_q.taken && !flush;
  assign br_target   = br_redirect ? main_q.target : 32'd0;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (m_valid && !m_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (br_redirect)         taken_cnt_d = taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: expected entries are queued at drive time and checked on drain.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_alu_result;
  logic [31:0] m_store_data;
  logic [4:0]  m_rd_addr;
  logic        m_reg_write;
  logic        m_mem_read;
  logic        m_mem_write;
  logic        flush;
  logic        br_redirect;
  logic [31:0] br_target;
  logic [31:0] stall_cnt;
  logic [31:0] taken_cnt;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

`ifdef EXMEM_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd7;
  localparam logic [31:0] EXP_TAKEN = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_TAKEN = 32'd0;
`endif

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .store_data(store_data),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .funct3(funct3), .pc(pc), .imm(imm),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_alu_result(m_alu_result), .m_store_data(m_store_data), .m_rd_addr(m_rd_addr),
    .m_reg_write(m_reg_write), .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .flush(flush), .br_redirect(br_redirect), .br_target(br_target),
    .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one entry onto the EX side and queue what should come out of the M side.
  task automatic load(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw,
                      input logic br, input logic [2:0] f3, input logic zf,
                      input logic [31:0] pcv, input logic [31:0] immv,
                      input logic tk, input logic [31:0] tgt);
    exp_t x;
    ex_valid = 1'b1; alu_result = a; store_data = sd; rd_addr = rd;
    reg_write = rw; mem_read = mr; mem_write = mw;
    branch = br; funct3 = f3; zero_flag = zf; pc = pcv; imm = immv;
    x.alu = a; x.sd = sd; x.rd = rd; x.rw = rw; x.mr = mr; x.mw = mw; x.tk = tk; x.tgt = tgt;
    q.push_back(x);
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!ex_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw,
                      input logic br, input logic [2:0] f3, input logic zf,
                      input logic [31:0] pcv, input logic [31:0] immv,
                      input logic tk, input logic [31:0] tgt);
    load(a, sd, rd, rw, mr, mw, br, f3, zf, pcv, immv, tk, tgt);
    wait_accept();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_left", 32'(q.size()), 32'd0);
  endtask

  // Output monitor: every hand-off must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready && !flush) begin
        chk("out_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("m_alu_result", m_alu_result, e.alu);
          chk("m_store_data", m_store_data, e.sd);
          chk("m_rd_addr", 32'(m_rd_addr), 32'(e.rd));
          chk("m_ctrl", {29'd0, m_reg_write, m_mem_read, m_mem_write}, {29'd0, e.rw, e.mr, e.mw});
          chk("br_redirect", 32'(br_redirect), 32'(e.tk));
          if (e.tk) chk("br_target", br_target, e.tgt);
        end
      end else begin
        chk("br_redirect_idle", 32'(br_redirect), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
    alu_result = '0; zero_flag = 1'b0; store_data = '0; rd_addr = '0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    branch = 1'b0; funct3 = '0; pc = '0; imm = '0;
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_br_redirect", 32'(br_redirect), 32'd0);
    chk("rst_m_alu_result", m_alu_result, 32'd0);
    chk("rst_br_target", br_target, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single entry, one-cycle latency.
    m_ready = 1'b1;
    send(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("single_m_valid", 32'(m_valid), 32'd1);
    chk("single_m_rd_addr", 32'(m_rd_addr), 32'd5);
    chk("single_m_alu_result", m_alu_result, 32'h10);
    @(posedge clk); #1;
    chk("single_gone", 32'(m_valid), 32'd0);

    // Back-pressure: A in main, B in skid, C held off.
    m_ready = 1'b0;
    send(32'hA0A0, 32'h1111, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    send(32'hB0B0, 32'h2222, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    load(32'hC0C0, 32'h3333, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("two_ex_ready", 32'(ex_ready), 32'd0);
    chk("two_m_valid", 32'(m_valid), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_ex_ready", 32'(ex_ready), 32'd0);
      chk("hold_main_A", m_alu_result, 32'hA0A0);
    end
    m_ready = 1'b1;
    wait_accept();
    wait_drain();

    // Branch decisions.
    send(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h100, 32'hFFFFFFF0, 1'b1, 32'hF0);
    send(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h100, 32'hFFFFFFF0, 1'b0, 32'hF0);
    send(32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 32'h200, 32'h8, 1'b0, 32'h208);
    send(32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h4);
    send(32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 32'h300, 32'h4, 1'b0, 32'h304);
    send(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h400, 32'h20, 1'b1, 32'h420);
    send(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 32'h500, 32'h20, 1'b0, 32'h520);
    wait_drain();

    // Flush with a taken branch in main and the skid full.
    m_ready = 1'b0;
    send(32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h600, 32'h40, 1'b1, 32'h640);
    send(32'h77, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("flush_pre_ex_ready", 32'(ex_ready), 32'd0);
    flush = 1'b1; m_ready = 1'b1;
    #1;
    chk("flush_no_redirect", 32'(br_redirect), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; m_ready = 1'b0;
    q.delete();
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_ex_ready", 32'(ex_ready), 32'd1);

    // Reset in the middle of a held entry.
    send(32'h99, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_ex_ready", 32'(ex_ready), 32'd1);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Counters: 7 stall cycles, then one taken branch drains.
    load(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h2000, 32'h10, 1'b1, 32'h2010);
    wait_accept();
    chk("first_accept_after_rst", 32'(m_valid), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("stall_cnt", stall_cnt, EXP_STALL);
    chk("taken_cnt", taken_cnt, EXP_TAKEN);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1 rising-edge clock; rst_n in 1 async active-low reset.
REQ-002 SHALL have these upstream ports (from the ALU/EX side): ex_valid in 1 entry offered; ex_ready out 1 entry accepted; alu_result in 32 ALU result; zero_flag in 1 ALU zero; store_data in 32 rs2 value; rd_addr in 5 destination register; reg_write in 1; mem_read in 1; mem_write in 1; branch in 1 conditional-branch instruction; funct3 in 3 branch condition; pc in 32 instruction PC; imm in 32 sign-extended branch offset.
REQ-003 SHALL have these downstream ports: m_valid out 1; m_ready in 1; m_alu_result out 32; m_store_data out 32; m_rd_addr out 5; m_reg_write out 1; m_mem_read out 1; m_mem_write out 1.
REQ-004 SHALL have these control ports: flush in 1 discard all held entries; br_redirect out 1 taken branch leaving stage; br_target out 32 redirect PC; stall_cnt out 32; taken_cnt out 32.

Function
REQ-005 SHALL hold up to 2 entries: a main (output) register and a skid register.
REQ-006 SHALL transfer upstream on a clock edge when ex_valid && ex_ready, and downstream when m_valid && m_ready.
REQ-007 SHALL drive ex_ready from a flop: ex_ready = !skid_valid; combinational paths from m_ready to ex_ready are forbidden.
REQ-008 SHALL have entry states EMPTY (no entry), ONE (main only), and TWO (main+skid); m_valid=1 in ONE and TWO.
REQ-009 SHALL apply these transitions: EMPTY+accept->ONE; ONE+accept+!drain->TWO; ONE+drain+!accept->EMPTY; ONE+accept+drain->ONE (new entry in main); TWO+drain->ONE (skid moves to main); TWO+!drain->TWO.
REQ-010 SHALL have a latency of 1 cycle: an entry accepted at edge N appears on m_* after edge N when the stage was EMPTY, or was ONE and draining.
REQ-011 SHALL compute the branch decision at accept: funct3 000 taken=zero_flag; 001 taken=!zero_flag; 100/110 taken=alu_result[0]; 101/111 taken=!alu_result[0]; 010/011 taken=0. Taken is forced to 0 when branch=0.
REQ-012 SHALL compute br_target = pc + imm (32-bit, wrap-around, carry discarded) at accept and store it with the entry.
REQ-013 SHALL pulse br_redirect=1 for exactly the cycle in which a main entry with taken=1 transfers downstream (m_valid && m_ready); br_target shall be valid only in that cycle.
REQ-014 SHALL keep m_* stable while m_valid && !m_ready.
REQ-015 SHALL make flush synchronous: at the edge, both entries are invalidated, and any same-cycle accept and drain are discarded with no br_redirect; flush has priority over all other events.
REQ-016 SHALL gate br_redirect with !flush in the flush cycle.

Reset
REQ-017 SHALL, on rst_n=0 (asynchronous), clear: m_valid=0, skid_valid=0, ex_ready=1, br_redirect=0, all m_* data, br_target, stall_cnt and taken_cnt =0.
REQ-018 SHALL, when reset asserts mid-transfer, drop all held entries; the first accept is possible on the first edge after rst_n rises.

Configuration
REQ-019 SHALL, with EXMEM_PERF_CNT_EN defined, compile in two counters: stall_cnt increments on each cycle with m_valid && !m_ready; taken_cnt increments on each br_redirect pulse. Both wrap 0xFFFFFFFF->0, are cleared only by reset, and are unaffected by flush.
REQ-020 SHALL, without EXMEM_PERF_CNT_EN, keep the stall_cnt and taken_cnt ports, tie them to 0, and instantiate no counter flops.

Verification
REQ-021 SHALL cover: reset, then a single entry (alu_result=0x00000010, rd=5, reg_write=1) with m_ready=1 -> m_valid=1 for 1 cycle after the edge, m_rd_addr=5, m_alu_result=0x10.
REQ-022 SHALL cover: m_ready=0 and three back-to-back ex_valid entries A,B,C -> A in main, B in skid, ex_ready=0, C held; then m_ready=1 -> A, B, C delivered in order, none lost or duplicated.
REQ-023 SHALL cover: branch=1, funct3=000, zero_flag=1, pc=0x00000100, imm=0xFFFFFFF0 -> br_redirect pulse on drain, br_target=0x000000F0; same stimulus with zero_flag=0 -> no pulse.
REQ-024 SHALL cover: funct3=101 (BGE), alu_result=0x00000001 -> not taken; funct3=110 (BLTU), alu_result=0x00000001 -> taken; funct3=010 -> never taken.
REQ-025 SHALL cover: stage in TWO with a taken branch in main, flush=1 with m_ready=1 -> no br_redirect, next cycle m_valid=0 and ex_ready=1.
REQ-026 SHALL cover, with EXMEM_PERF_CNT_EN: hold m_ready=0 for 7 cycles with m_valid=1, then drain one taken branch -> stall_cnt=7, taken_cnt=1; without the macro -> both read 0.
